// File: rtl/wb_reg_writer.sv
// Write-back stage: in-order result FIFO feeding the register-file write port.
// Optional result forwarding lookup is built when WB_FWD_EN is defined.
module wb_reg_writer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic [4:0]  reg_write,
    output logic [31:0] data_write,
`ifdef WB_FWD_EN
    input  logic [4:0]  fwd_rs1,
    input  logic [4:0]  fwd_rs2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2,
`endif
    output logic [2:0]  wb_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
    localparam logic [2:0] DEPTH_M1 = 3'(DEPTH - 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW-1:0]   ex_slot;
    logic [2:0]      cnt_q, cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     data_q, data_d;
    logic            mem_push, ex_push, pop;

    // Ready is a function of the registered count only, so both sources
    // always fit in the same cycle regardless of the pop.
    assign mem_ready = (cnt_q < DEPTH_C);
    assign ex_ready  = (cnt_q < DEPTH_M1);

    always_comb begin
        mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
        ex_push  = ex_valid && ex_ready && (ex_rd != 5'd0);
        pop      = (cnt_q != 3'd0);
        ex_slot  = mem_push ? wptr_q + AW'(1) : wptr_q;
        wptr_d   = wptr_q + AW'(mem_push) + AW'(ex_push);
        rptr_d   = pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d    = cnt_q + 3'(mem_push) + 3'(ex_push) - 3'(pop);
        rd_d     = 5'd0;
        data_d   = 32'd0;
        if (pop) begin
            rd_d   = fifo_q[rptr_q].rd;
            data_d = fifo_q[rptr_q].data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= 3'd0;
            rd_q   <= 5'd0;
            data_q <= 32'd0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (mem_push)
            fifo_q[wptr_q] <= '{rd: mem_rd, data: mem_data};
        if (ex_push)
            fifo_q[ex_slot] <= '{rd: ex_rd, data: ex_data};
    end

    assign reg_write  = rd_q;
    assign data_write = data_q;
    assign wb_count   = cnt_q;

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest match overrides.
    function automatic logic [32:0] fwd_lookup(input logic [4:0] rs);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = 33'd0;
        if (rs != 5'd0) begin
            if (rd_q == rs)
                res = {1'b1, data_q};
            for (int i = 0; i < DEPTH; i++) begin
                idx = rptr_q + AW'(i);
                if ((3'(i) < cnt_q) && (fifo_q[idx].rd == rs))
                    res = {1'b1, fifo_q[idx].data};
            end
        end
        return res;
    endfunction

    always_comb begin
        {fwd_hit1, fwd_data1} = fwd_lookup(fwd_rs1);
        {fwd_hit2, fwd_data2} = fwd_lookup(fwd_rs2);
    end
`endif

endmodule

// File: tb/tb_wb_reg_writer.sv
// Scoreboard bench for wb_reg_writer: expected writes are queued on
// accepted handshakes and popped when the register-file port fires.
module tb_wb_reg_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_data = 32'd0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = 5'd0;
    logic [31:0] mem_data = 32'd0;
    logic [4:0]  reg_write;
    logic [31:0] data_write;
    logic [2:0]  wb_count;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs1 = 5'd0;
    logic [4:0]  fwd_rs2 = 5'd0;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    always #5 clk = ~clk;

    wb_reg_writer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .reg_write  (reg_write),
        .data_write (data_write),
`ifdef WB_FWD_EN
        .fwd_rs1    (fwd_rs1),
        .fwd_rs2    (fwd_rs2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
`endif
        .wb_count   (wb_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_chk = 0;
    int   n_err = 0;
    int   mdl_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("wb_count", 32'(wb_count), 32'(mdl_cnt));
            if (reg_write != 5'd0) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected", 32'(reg_write), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("wb_rd", 32'(reg_write), 32'(e.rd));
                    check("wb_data", data_write, e.d);
                end
            end else begin
                check("idle_data", data_write, 32'd0);
            end
        end
    end

    task automatic cycle(input bit mv, input logic [4:0] mrd,
                         input logic [31:0] md, input bit ev,
                         input logic [4:0] erd, input logic [31:0] ed,
                         output bit macc, output bit eacc);
        bit r_m, r_e;
        int pushes;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        ex_valid = ev; ex_rd = erd; ex_data = ed;
        r_m = (mdl_cnt < DEPTH);
        r_e = (mdl_cnt < DEPTH - 1);
        check("mem_ready", 32'(mem_ready), 32'(r_m));
        check("ex_ready", 32'(ex_ready), 32'(r_e));
        macc = mv && r_m;
        eacc = ev && r_e;
        @(posedge clk);
        pushes = 0;
        if (macc && mrd != 5'd0) begin
            sbq.push_back('{rd: mrd, d: md});
            pushes++;
        end
        if (eacc && erd != 5'd0) begin
            sbq.push_back('{rd: erd, d: ed});
            pushes++;
        end
        mdl_cnt = mdl_cnt + pushes - ((mdl_cnt > 0) ? 1 : 0);
        #1;
        mem_valid = 1'b0;
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a, b;
        for (int i = 0; i < n; i++)
            cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, a, b);
    endtask

    task automatic do_reset();
        mem_valid = 1'b0;
        ex_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        mdl_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a, b, seen_low;
        logic [4:0]  mrd, erd;
        logic [31:0] md, ed;
        int          k;

        #1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            check("rst_rd", 32'(reg_write), 32'd0);
            check("rst_data", data_write, 32'd0);
            check("rst_cnt", 32'(wb_count), 32'd0);
            idle(1);
        end

        cycle(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234, a, b);
        check("lat_pre", 32'(reg_write), 32'd0);
        idle(1);
        check("lat_rd", 32'(reg_write), 32'd5);
        check("lat_data", data_write, 32'h1234);
        idle(1);
        check("lat_post", 32'(reg_write), 32'd0);

        cycle(1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB, a, b);
        idle(1);
        check("ord_rd0", 32'(reg_write), 32'd3);
        check("ord_d0", data_write, 32'hAAAA);
        idle(1);
        check("ord_rd1", 32'(reg_write), 32'd3);
        check("ord_d1", data_write, 32'hBBBB);
        idle(2);

        seen_low = 0;
        k = 0;
        mrd = 5'd1; md = $urandom;
        erd = 5'd0; ed = $urandom;
        for (int i = 0; i < 30; i++) begin
            if (!ex_ready) seen_low = 1;
            cycle(1, mrd, md, 1, erd, ed, a, b);
            if (a) begin
                k++;
                mrd = (k % 5 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                md = $urandom;
            end
            if (b) begin
                k++;
                erd = (k % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ed = $urandom;
            end
        end
        check("ex_ready_drop", 32'(seen_low), 32'd1);
        idle(8);
        check("drain1", 32'(sbq.size()), 32'd0);

        cycle(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, a, b);
        cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, a, b);
        do_reset();
        check("rst_mid_rd", 32'(reg_write), 32'd0);
        check("rst_mid_cnt", 32'(wb_count), 32'd0);
        idle(6);

`ifdef WB_FWD_EN
        cycle(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, a, b);
        fwd_rs1 = 5'd7;
        fwd_rs2 = 5'd0;
        #1;
        check("fwd_hit1", 32'(fwd_hit1), 32'd1);
        check("fwd_data1", fwd_data1, 32'h2);
        check("fwd_hit2", 32'(fwd_hit2), 32'd0);
        check("fwd_data2", fwd_data2, 32'd0);
        fwd_rs1 = 5'd0;
        idle(4);
`endif

        check("drain_end", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
